// File: rtl/fwd_hazard_pkg.sv
// -----------------------------------------------------------------------------
// fwd_hazard_pkg
// Shared constants, types and helpers for the forwarding / hazard unit.
//   FWD_SEL_RF  : forward-select code meaning "take operand from register file"
//   fwd_sel_w() : width of one forward-select field for a given producer depth
//   reg_addr_t  : register address type for the default 32-entry register file
// -----------------------------------------------------------------------------
package fwd_hazard_pkg;

    localparam int FWD_SEL_RF = 0;
    localparam int REG_AW_DEF = 5;

    typedef logic [REG_AW_DEF-1:0] reg_addr_t;

    // Code 0 is the register file, codes 1..depth are producer stages.
    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ld_scoreboard.sv
// -----------------------------------------------------------------------------
// ld_scoreboard
// Tracks destination registers of non-blocking loads that left MEM without
// data. Holds a busy bitmap (x0 never busy), an outstanding-load counter and a
// sticky error flag for completions that match no outstanding load.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_rs_addr_d       packed decode-stage source addresses (port 0 at LSBs)
//   i_ex_rd           EX-stage destination (for WAW lookup)
//   i_ld_issue(_rd)   load leaves MEM without data / its destination
//   i_ld_done(_rd)    load data returned this cycle / its destination
//   o_busy_d          per decode port: source register awaits load data
//   o_busy_ex         EX destination awaits load data
//   o_ld_full         counter at MAX_OUTSTANDING
//   o_err_spurious    sticky: completion for a register that was not busy
// -----------------------------------------------------------------------------
module ld_scoreboard
    import fwd_hazard_pkg::*;
#(
    parameter int NUM_SRC         = 2,
    parameter int REG_AW          = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] i_rs_addr_d,
    input  logic [REG_AW-1:0]         i_ex_rd,
    input  logic                      i_ld_issue,
    input  logic [REG_AW-1:0]         i_ld_issue_rd,
    input  logic                      i_ld_done,
    input  logic [REG_AW-1:0]         i_ld_done_rd,
    output logic [NUM_SRC-1:0]        o_busy_d,
    output logic                      o_busy_ex,
    output logic                      o_ld_full,
    output logic                      o_err_spurious
);

    localparam int NREG  = 2**REG_AW;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [NREG-1:1]  r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [NREG-1:0]  w_busy_all;
    logic [NREG-1:1]  w_busy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_ok;
    logic             w_issue_ok;

    // Bit 0 is tied low so x0 lookups never report busy.
    assign w_busy_all = {r_busy, 1'b0};
    assign o_ld_full  = (r_cnt == CNT_W'(MAX_OUTSTANDING));
    assign o_err_spurious = r_err;
    assign o_busy_ex  = w_busy_all[i_ex_rd];

    always_comb begin
        o_busy_d = '0;
        for (int p = 0; p < NUM_SRC; p++) begin
            o_busy_d[p] = w_busy_all[i_rs_addr_d[p*REG_AW +: REG_AW]];
        end
    end

    // Completion is applied before issue so a same-register done+issue
    // leaves the register busy and the count unchanged.
    always_comb begin
        w_busy_nxt = r_busy;
        w_done_ok  = i_ld_done && w_busy_all[i_ld_done_rd];
        // An issue into a full scoreboard with no completion is dropped.
        w_issue_ok = i_ld_issue && (i_ld_issue_rd != '0) &&
                     !(o_ld_full && !w_done_ok);
        if (w_done_ok) begin
            w_busy_nxt[i_ld_done_rd] = 1'b0;
        end
        if (w_issue_ok) begin
            w_busy_nxt[i_ld_issue_rd] = 1'b1;
        end
        w_cnt_nxt = r_cnt - CNT_W'(w_done_ok) + CNT_W'(w_issue_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            if (i_ld_done && !w_busy_all[i_ld_done_rd]) begin
                r_err <= 1'b1;
            end
            assert (!(i_ld_issue && o_ld_full && !i_ld_done))
                else $error("ld_scoreboard: load issued while scoreboard full");
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// EX-stage operand forwarding with youngest-producer priority, decode-stage
// load-use stall/flush, and stalls driven by a non-blocking load scoreboard.
// Optional macro FWD_HAZARD_PERF_EN adds saturating stall / forward counters.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   rs_addr_e / rs_addr_d  packed EX / decode source addresses (port 0 at LSBs)
//   prod_addr/_we/_rdy     per producer stage (0 = EX/MEM, youngest)
//   ex_is_load, ex_rd      load currently in EX and its destination
//   ld_issue(_rd)          non-blocking load leaves MEM without data
//   ld_done(_rd)           load data returned and written back
//   fwd_sel                per port: 0 = register file, k = producer stage k-1
//   stall_d, flush_e       hold IF/ID and PC / bubble into ID/EX
//   ld_full, err_spurious  scoreboard full / sticky spurious completion
//   perf_stall_cnt, perf_fwd_cnt  (FWD_HAZARD_PERF_EN only)
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int NUM_SRC         = 2,
    parameter int FWD_DEPTH       = 2,
    parameter int REG_AW          = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SEL_W           = fwd_sel_w(FWD_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   rs_addr_e,
    input  logic [NUM_SRC*REG_AW-1:0]   rs_addr_d,
    input  logic [FWD_DEPTH*REG_AW-1:0] prod_addr,
    input  logic [FWD_DEPTH-1:0]        prod_we,
    input  logic [FWD_DEPTH-1:0]        prod_rdy,
    input  logic                        ex_is_load,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ld_issue,
    input  logic [REG_AW-1:0]           ld_issue_rd,
    input  logic                        ld_done,
    input  logic [REG_AW-1:0]           ld_done_rd,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        stall_d,
    output logic                        flush_e,
    output logic                        ld_full,
    output logic                        err_spurious
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]                 perf_stall_cnt,
    output logic [31:0]                 perf_fwd_cnt
`endif
);

    logic [NUM_SRC-1:0] w_busy_d;
    logic               w_busy_ex;
    logic               w_load_use;
    logic               w_unused;

    // A not-ready producer is still selected; the stall for it was raised
    // in decode the cycle before, so readiness never changes the mux.
    assign w_unused = ^prod_rdy;

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd_sel = '0;
        for (int p = 0; p < NUM_SRC; p++) begin : g_port
            logic [REG_AW-1:0] v_rs;
            logic [SEL_W-1:0]  v_sel;
            v_rs  = rs_addr_e[p*REG_AW +: REG_AW];
            v_sel = SEL_W'(FWD_SEL_RF);
            for (int s = FWD_DEPTH - 1; s >= 0; s--) begin
                if (prod_we[s] && (prod_addr[s*REG_AW +: REG_AW] != '0) &&
                    (prod_addr[s*REG_AW +: REG_AW] == v_rs)) begin
                    v_sel = SEL_W'(s + 1);
                end
            end
            fwd_sel[p*SEL_W +: SEL_W] = v_sel;
        end
    end

    always_comb begin
        w_load_use = 1'b0;
        for (int p = 0; p < NUM_SRC; p++) begin
            if (rs_addr_d[p*REG_AW +: REG_AW] == ex_rd) begin
                w_load_use = 1'b1;
            end
        end
        w_load_use = w_load_use && ex_is_load && (ex_rd != '0);
    end

    ld_scoreboard #(
        .NUM_SRC         (NUM_SRC),
        .REG_AW          (REG_AW),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk            (clk),
        .rst            (rst),
        .i_rs_addr_d    (rs_addr_d),
        .i_ex_rd        (ex_rd),
        .i_ld_issue     (ld_issue),
        .i_ld_issue_rd  (ld_issue_rd),
        .i_ld_done      (ld_done),
        .i_ld_done_rd   (ld_done_rd),
        .o_busy_d       (w_busy_d),
        .o_busy_ex      (w_busy_ex),
        .o_ld_full      (ld_full),
        .o_err_spurious (err_spurious)
    );

    // Only the load-use case needs a bubble; scoreboard stalls just hold decode.
    assign flush_e = w_load_use;
    assign stall_d = w_load_use
                   | (|w_busy_d)
                   | (ex_is_load & w_busy_ex)
                   | (ex_is_load & ld_full & ~ld_done);

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_fwd   <= '0;
        end else begin
            if (stall_d && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if ((fwd_sel != '0) && (r_perf_fwd != '1)) begin
                r_perf_fwd <= r_perf_fwd + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_fwd_cnt   = r_perf_fwd;
`endif

endmodule
